// File: rtl/square_iter.sv
// square_iter: iterative fixed-point squarer, Q13 root in, Q23 square out.
// A shift-add multiplier retires one multiplier bit per clock, so a single
// 34-bit adder is shared across all 17 partial products. Valid/ready
// handshakes on both sides; the block holds one operand at a time.
module square_iter #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] root_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] sq_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ROUND,
    DONE
  } state_t;

  // The Q26 product is reduced to Q23 by dropping three bits; adding half
  // an output LSB first turns the truncation into round-half-up.
  localparam logic [33:0] ROUND_ADD = ROUND_EN ? 34'd4 : 34'd0;

  state_t      state;
  state_t      state_next;
  logic [33:0] mcand;
  logic [33:0] acc;
  logic [16:0] mplier;
  logic [4:0]  cnt;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; in_ready and busy depend on state alone so neither
  // handshake input has a combinational path to an output.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == 5'd16) begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture on accept, one shift-add step per MUL cycle,
  // scaling in ROUND, and the result held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      sq_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {17'b0, root_in};
            mplier <= root_in;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        ROUND: begin
          sq_out    <= 31'((acc + ROUND_ADD) >> 3);
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_iter.sv
// tb_square_iter: directed and randomised checks of square_iter with both
// rounding modes instantiated side by side on shared inputs.
module tb_square_iter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [16:0] root_in;
  logic        out_ready;

  logic        in_ready1;
  logic        out_valid1;
  logic        busy1;
  logic [30:0] sq_out1;
  logic        in_ready0;
  logic        out_valid0;
  logic        busy0;
  logic [30:0] sq_out0;

  int tests;
  int failures;

  square_iter #(.ROUND_EN(1'b1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .root_in   (root_in),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .sq_out    (sq_out1),
    .busy      (busy1)
  );

  square_iter #(.ROUND_EN(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .root_in   (root_in),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .sq_out    (sq_out0),
    .busy      (busy0)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [33:0] observed,
                             input logic [33:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present an operand and wait (bounded) for the accepting edge; returns on
  // the falling edge after the accept, with root_in scrambled to show that
  // only the accept-edge value matters.
  task automatic applyStimulus(input string tag, input logic [16:0] root);
    int n;
    in_valid = 1'b1;
    root_in  = root;
    n = 0;
    while (!in_ready1 && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput({tag, " accept timeout"}, 34'(n), 34'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    root_in  = 17'($urandom);
  endtask

  // One complete transaction: accept, latency and value checks for both
  // modes, optional backpressure hold, then consume.
  task automatic runOp(input string tag, input logic [16:0] root,
                       input logic [30:0] exp1, input logic [30:0] exp0,
                       input int hold, input bit press_in);
    int count;
    out_ready = (hold == 0);
    applyStimulus(tag, root);
    count = 0;
    while (count < 40) begin
      if (press_in) begin
        in_valid = 1'b1;
        root_in  = 17'h03000;
      end
      @(posedge clk);
      @(negedge clk);
      count++;
      if (count == 9) checkOutput({tag, " busy mid"}, {32'd0, busy1, in_ready1}, 34'b10);
      if (out_valid1) break;
    end
    checkOutput({tag, " latency"}, 34'(count), 34'd18);
    checkOutput({tag, " round"}, {3'd0, sq_out1}, {3'd0, exp1});
    checkOutput({tag, " trunc"}, {3'd0, sq_out0}, {3'd0, exp0});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " hold"}, {out_valid1, out_valid0, in_ready1, sq_out1},
                  {1'b1, 1'b1, 1'b0, exp1});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " consumed"}, {31'd0, out_valid1, out_valid0, in_ready1}, 34'b001);
  endtask

  // Directed sequence followed by a randomised round-trip run.
  initial begin
    int seen;
    logic [16:0] x;
    longint unsigned sq;
    tests     = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    root_in   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset flags", {28'd0, in_ready1, busy1, out_valid1, in_ready0, busy0, out_valid0},
                34'b100100);
    checkOutput("reset sq", {3'd0, sq_out1 | sq_out0}, 34'd0);

    runOp("one",  17'h02000, 31'h0800000, 31'h0800000, 0, 1'b0);
    runOp("1p5",  17'h03000, 31'h1200000, 31'h1200000, 0, 1'b0);
    runOp("two",  17'h04000, 31'h2000000, 31'h2000000, 0, 1'b0);
    runOp("zero", 17'h00000, 31'h0,       31'h0,       0, 1'b0);
    runOp("max",  17'h1FFFF, 31'h7FFF8000, 31'h7FFF8000, 0, 1'b0);
    runOp("r2",   17'h00002, 31'h1, 31'h0, 0, 1'b0);
    runOp("r1",   17'h00001, 31'h0, 31'h0, 0, 1'b0);
    runOp("r3",   17'h00003, 31'h1, 31'h1, 0, 1'b0);

    // Backpressure with a second operand waiting; it must come out next.
    runOp("bp",   17'h02000, 31'h0800000, 31'h0800000, 5, 1'b1);
    runOp("bp2",  17'h03000, 31'h1200000, 31'h1200000, 0, 1'b0);

    // Abort at T9: no result may ever appear for that operand.
    out_ready = 1'b1;
    applyStimulus("abort", 17'h04000);
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort idle", {31'd0, in_ready1, busy1, out_valid1}, 34'b100);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid1 || out_valid0) seen++;
    end
    checkOutput("abort no out_valid", 34'(seen), 34'd0);
    runOp("post abort", 17'h02000, 31'h0800000, 31'h0800000, 0, 1'b0);

    // Random operands with random idle gaps and consumer stalls.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      x  = 17'($urandom_range(0, 17'h1FFFF));
      sq = longint'(x) * longint'(x);
      runOp("rand", x, 31'((sq + 4) >> 3), 31'(sq >> 3), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/square_iter.md
# square_iter

Iterative fixed-point squarer: the inverse of the polynomial square-root stage in the AWGN datapath. Takes a Q13 root, the same 17-bit format the square-root block produces, and returns its square in Q23, the same 31-bit format the square-root block consumes. It is used as the round-trip checker and reconstruction path for the Box-Muller magnitude: root in, squared value out. It uses a shift-add multiplier (one bit per cycle) behind valid/ready handshakes, trading latency for a single adder.

## Interface
Parameters:
- ROUND_EN, 1, final scaling rule: 1 = round-half-up, 0 = truncate.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on clk rising edge.
- in_valid  in  1  root_in is valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- root_in  in  17  unsigned Q13 operand (4 integer, 13 fraction bits).
- out_valid  out  1  sq_out is valid.
- out_ready  in  1  downstream accepts sq_out.
- sq_out  out  31  unsigned Q23 square (8 integer, 23 fraction bits).
- busy  out  1  high in MUL, ROUND and DONE.

## Operation
- State machine: IDLE, MUL, ROUND, DONE.
- **IDLE**
  - in_ready = 1.
  - On an edge with in_valid=1: load mcand = {17'b0, root_in} (34 bits), mplier = root_in, acc = 0, cnt = 0. Go to MUL.
- **MUL**, one edge per multiplier bit:
  - if mplier[0], acc <= acc + mcand;
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - After the 17th MUL edge (cnt==16 at that edge), go to ROUND.
- **Widths**
  - acc is 34 bits: Q26 exact product. The maximum (2^17-1)^2 < 2^34, so acc never overflows.
  - The adder is 34 bits, unsigned.
- **ROUND**
  - ROUND_EN=1: sq_out <= (acc + 4) >> 3.
  - ROUND_EN=0: sq_out <= acc >> 3.
  - The result fits 31 bits in both modes: the maximum is 0x7FFF8000. No saturation logic.
  - Set out_valid <= 1 and go to DONE.
- **DONE**
  - Hold sq_out and out_valid stable while out_ready=0.
  - On an edge with out_ready=1: clear out_valid and go to IDLE.
  - in_ready stays 0 in DONE. A new operand is accepted no earlier than the next cycle in IDLE.
- **Combinational outputs**: in_ready and busy decode from state only. No combinational path from in_valid or out_ready to any output.
- **Input sampling**: root_in is sampled only on the accepting edge. Changes to root_in or in_valid outside IDLE are ignored.
- **Zero operand**: runs the full 17 MUL cycles and returns sq_out=0. There is no early termination.
- **Reset**
  - Values: state=IDLE, out_valid=0, sq_out=0, acc=0, cnt=0, mcand=0, mplier=0. Resulting outputs: in_ready=1, busy=0.
  - Reset wins over any simultaneous handshake.
  - Reset mid-operation (MUL, ROUND or DONE) aborts the operation. No out_valid pulse follows.

## Timing
- Latency:
  - Accept edge T0.
  - MUL edges T1..T17.
  - ROUND edge T18.
  - out_valid is high after T18, so it is first visible in the cycle following edge T18.
- Minimum initiation interval is 20 cycles:
  - 18 cycles from accept to result;
  - 1 DONE cycle with out_ready=1;
  - 1 IDLE cycle.
- While busy, in_ready=0. Upstream holds in_valid/root_in (AXI-stream style); the block never drops an asserted operand.
- out_valid, once high, stays high until consumed. sq_out is unchanged while out_valid=1.

## Test plan
- **Reset values**: assert reset 2 cycles, then hold in_valid=0 and out_ready=0 for 1 cycle.
  - Require in_ready=1, busy=0, out_valid=0, sq_out=0.
- **Basic values**, ROUND_EN=1, out_ready=1, each accepted at T0.
  - root_in=0x02000 (1.0): sq_out=0x0800000 exactly 18 edges later.
  - root_in=0x03000 (1.5): sq_out=0x1200000.
  - root_in=0x04000 (2.0): sq_out=0x2000000.
  - root_in=0: sq_out=0.
- **Extremes and rounding**: root_in=0x1FFFF gives sq_out=0x7FFF8000 in both modes.
  - ROUND_EN=1: root_in=2 gives 1; root_in=1 gives 0; root_in=3 gives 1.
  - ROUND_EN=0: root_in=2 gives 0.
- **Backpressure and busy**: root_in=0x02000, out_ready=0 for 5 cycles after out_valid rises, then 1.
  - Require out_valid and sq_out=0x0800000 held for all 5 cycles.
  - Require a single consume edge, then IDLE the next cycle.
  - A second in_valid driven during busy is not accepted until in_ready=1.
- **Reset mid-op**: accept root_in=0x04000, then assert reset at T9 for 1 cycle.
  - Require no out_valid ever for that operand.
  - A following root_in=0x02000 returns 0x0800000 with normal 18-cycle latency.
- **Random round-trip**: 10k random 17-bit operands with random in_valid/out_ready gaps, both ROUND_EN values.
  - Compare against a model: (x*x + (ROUND_EN?4:0)) >> 3.
  - Check in-order results, no drops, no duplicates.
